// File: rtl/sprite_fetch_pkg.sv
// Shared types, default widths and helpers for the sprite row fetch master.
package sprite_fetch_pkg;

  localparam int DEF_ADDR_W     = 7;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_LEN_W      = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_FETCH  = 2'd1;
  localparam state_t ST_DRAIN  = 2'd2;
  localparam state_t ST_FINISH = 2'd3;

  // Count must represent 0..depth inclusive, hence one bit more than the pointer.
  function automatic int fifo_count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sprite_fetch_fifo.sv
// First-word-fall-through skid FIFO with occupancy count; head reads as zero when empty.
module sprite_fetch_fifo
  import sprite_fetch_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_FIFO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = fifo_count_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic [CNT_W-1:0]  count,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              full;
  logic              push_ok;
  logic              pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop_ok);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; the pointers and count alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/sprite_fetch_master.sv
// Avalon-MM read master streaming one sprite row from ROM into a valid/ready pixel stream.
// Optional build macro SPRITE_FETCH_MIRROR_EN adds a mirror input for descending (flipped) rows.
module sprite_fetch_master
  import sprite_fetch_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
`ifdef SPRITE_FETCH_MIRROR_EN
  input  logic              mirror,
`endif
  input  logic [ADDR_W-1:0] start_base,
  input  logic [LEN_W-1:0]  start_len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready
);

  localparam int CNT_W = fifo_count_w(FIFO_DEPTH);
  localparam int OCC_W = CNT_W + 1;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  remaining_q;
  logic              inflight_q;
  logic              step_down;
  logic [ADDR_W-1:0] first_addr;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic [OCC_W-1:0]  occupancy;
  logic              issue;
  logic              pop;
  logic              last_pop;

`ifdef SPRITE_FETCH_MIRROR_EN
  logic step_down_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      step_down_q <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      step_down_q <= mirror;
    end
  end

  assign step_down  = step_down_q;
  // Mirrored rows begin at the far end; the sum wraps modulo 2**ADDR_W like the ascending walk.
  assign first_addr = mirror ? (start_base + ADDR_W'(start_len) - ADDR_W'(1)) : start_base;
`else
  assign step_down  = 1'b0;
  assign first_addr = start_base;
`endif

  // Words already buffered plus the one still in the ROM pipeline must fit in the FIFO.
  assign occupancy = {1'b0, fifo_count} + OCC_W'(inflight_q);
  assign issue     = (state == ST_FETCH) && (occupancy < OCC_W'(FIFO_DEPTH));
  assign pop       = pix_valid & pix_ready;
  assign last_pop  = pop && (fifo_count == CNT_W'(1));

  // NOTE: next-state starts from a default so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nxt = (start_len == '0) ? ST_FINISH : ST_FETCH;
      end
      ST_FETCH: begin
        if (issue && remaining_q == LEN_W'(1)) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Leaving on the last handshake lets done follow it by exactly one cycle.
        if (!inflight_q && (fifo_empty || last_pop)) state_nxt = ST_FINISH;
      end
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state      <= state_nxt;
      inflight_q <= issue;
      if (state == ST_IDLE && start) begin
        addr_q      <= first_addr;
        remaining_q <= start_len;
      end else if (issue) begin
        addr_q      <= step_down ? (addr_q - ADDR_W'(1)) : (addr_q + ADDR_W'(1));
        remaining_q <= remaining_q - LEN_W'(1);
      end
    end
  end

  assign mem_address    = addr_q;
  assign mem_chipselect = issue;
  assign mem_clken      = issue;
  assign busy           = (state != ST_IDLE);
  assign done           = (state == ST_FINISH);
  assign pix_valid      = ~fifo_empty;

  sprite_fetch_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight_q),
    .push_data (mem_readdata),
    .pop       (pop),
    .pop_data  (pix_data),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_sprite_fetch_master.sv
// Directed bench for sprite_fetch_master against a 1-cycle ROM holding 16'hA000 | address.
// Build with SPRITE_FETCH_MIRROR_EN defined to also cover the mirrored walk.
module tb_sprite_fetch_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        mirror;
  logic [6:0]  start_base;
  logic [7:0]  start_len;
  logic        busy;
  logic        done;
  logic [6:0]  mem_address;
  logic        mem_chipselect;
  logic        mem_clken;
  logic [15:0] mem_readdata;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [6:0]  strobe_q[$];
  int          strobe_cyc_q[$];
  logic [15:0] pix_q[$];
  int          pix_cyc_q[$];
  int          done_cnt;
  int          done_cyc;
  int          valid_cnt;
  int          stall_viol;
  logic        prev_stall;
  logic [15:0] prev_data;

  always #5 clk = ~clk;

  sprite_fetch_master dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
`ifdef SPRITE_FETCH_MIRROR_EN
    .mirror         (mirror),
`endif
    .start_base     (start_base),
    .start_len      (start_len),
    .busy           (busy),
    .done           (done),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata),
    .pix_data       (pix_data),
    .pix_valid      (pix_valid),
    .pix_ready      (pix_ready)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_chipselect) mem_readdata <= 16'hA000 | {9'd0, mem_address};
  end

  // Logs bus activity mid-cycle, when DUT outputs and bench inputs are settled.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (mem_chipselect) begin
        strobe_q.push_back(mem_address);
        strobe_cyc_q.push_back(cyc);
      end
      if (pix_valid) valid_cnt++;
      if (pix_valid && pix_ready) begin
        pix_q.push_back(pix_data);
        pix_cyc_q.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (prev_stall && (!pix_valid || pix_data !== prev_data)) stall_viol++;
      prev_stall = pix_valid && !pix_ready;
      prev_data  = pix_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    strobe_q.delete();
    strobe_cyc_q.delete();
    pix_q.delete();
    pix_cyc_q.delete();
    done_cnt   = 0;
    done_cyc   = 0;
    valid_cnt  = 0;
    stall_viol = 0;
  endtask

  task automatic start_op(input logic [6:0] base, input logic [7:0] len, input logic mir);
    @(posedge clk); #1;
    start      = 1'b1;
    start_base = base;
    start_len  = len;
    mirror     = mir;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int n = 0; n < budget && done_cnt == 0; n++) @(posedge clk);
    repeat (3) @(posedge clk);
    check({tag, "_done_pulses"}, done_cnt, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_addr"},  mem_address, 0);
    check({tag, "_cs"},    mem_chipselect, 0);
    check({tag, "_clken"}, mem_clken, 0);
    check({tag, "_valid"}, pix_valid, 0);
    check({tag, "_data"},  pix_data, 0);
  endtask

  // Expected address i of a walk: ascending from base, or descending from base+n-1, modulo 128.
  task automatic check_run(input string tag, input logic [6:0] base, input int n, input bit down);
    logic [6:0] a;
    check({tag, "_nstrobe"}, strobe_q.size(), n);
    check({tag, "_npix"}, pix_q.size(), n);
    for (int i = 0; i < n; i++) begin
      a = down ? 7'(int'(base) + n - 1 - i) : 7'(int'(base) + i);
      if (i < strobe_q.size()) check($sformatf("%s_addr%0d", tag, i), strobe_q[i], a);
      if (i < pix_q.size())    check($sformatf("%s_pix%0d", tag, i), pix_q[i], 16'hA000 | {9'd0, a});
    end
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    mirror     = 1'b0;
    start_base = '0;
    start_len  = '0;
    pix_ready  = 1'b1;
    mem_readdata = '0;
    clear_log();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst");

    // 1) ascending row, stream always ready
    clear_log();
    start_op(7'h10, 8'd4, 1'b0);
    wait_done("t1", 40);
    check_run("t1", 7'h10, 4, 1'b0);
    for (int i = 1; i < strobe_cyc_q.size(); i++)
      check($sformatf("t1_consec%0d", i), strobe_cyc_q[i] - strobe_cyc_q[0], i);
    if (pix_cyc_q.size() == 4) check("t1_done_after_last", done_cyc - pix_cyc_q[3], 1);
    else                       check("t1_done_after_last", pix_cyc_q.size(), 4);
    check("t1_idle_busy", busy, 0);

    // 2) backpressure: FIFO + in-flight read cap the outstanding strobes at 4
    clear_log();
    pix_ready = 1'b0;
    start_op(7'h00, 8'd8, 1'b0);
    repeat (11) @(posedge clk);
    @(negedge clk); #1;
    check("t2_stall_strobes", strobe_q.size(), 4);
    check("t2_stall_cs", mem_chipselect, 0);
    check("t2_stall_valid", pix_valid, 1);
    @(posedge clk); #1 pix_ready = 1'b1;
    wait_done("t2", 60);
    check_run("t2", 7'h00, 8, 1'b0);
    check("t2_stable", stall_viol, 0);

    // 3) address wrap at the top of the ROM
    clear_log();
    start_op(7'h7E, 8'd4, 1'b0);
    wait_done("t3", 40);
    check_run("t3", 7'h7E, 4, 1'b0);

    // 4) zero-length request; a second start during FINISH is ignored
    clear_log();
    @(posedge clk); #1;
    start = 1'b1; start_base = 7'h20; start_len = 8'd0; mirror = 1'b0;
    @(posedge clk); #1;
    start_base = 7'h40; start_len = 8'd3;
    @(negedge clk);
    check("t4_busy1", busy, 1);
    check("t4_done1", done, 1);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("t4_busy2", busy, 0);
    check("t4_done2", done, 0);
    repeat (8) @(posedge clk);
    check("t4_nstrobe", strobe_q.size(), 0);
    check("t4_done_pulses", done_cnt, 1);

    // 5) synchronous reset during the third strobe of a len=8 fetch
    clear_log();
    start_op(7'h00, 8'd8, 1'b0);
    for (int n = 0; n < 40 && strobe_q.size() < 3; n++) begin
      @(negedge clk); #1;
    end
    check("t5_third_strobe", strobe_q.size(), 3);
    check("t5_cs_at_reset", mem_chipselect, 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("t5");
    @(posedge clk); #1 reset = 1'b0;
    clear_log();
    repeat (10) @(posedge clk);
    check("t5_no_valid", valid_cnt, 0);
    check("t5_no_strobe", strobe_q.size(), 0);
    start_op(7'h05, 8'd2, 1'b0);
    wait_done("t5b", 40);
    check_run("t5b", 7'h05, 2, 1'b0);

`ifdef SPRITE_FETCH_MIRROR_EN
    // 6) mirrored row walks the addresses downwards
    clear_log();
    start_op(7'h10, 8'd4, 1'b1);
    wait_done("t6", 40);
    check_run("t6", 7'h10, 4, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
